mips_multicycle_core: RTL and testbench

Parametrised multi-cycle MIPS core that replaces the single-cycle datapath with one shared memory port, a control FSM and a request/ready handshake. Instructions and data share one port, and memory may insert any number of wait states. It sits between the SoC memory fabric and the debug/trace logic and exposes PC, retire and halt status.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mips_mc_ctrl.sv | 164 ++++++++++++++++
 rtl/mips_multicycle_core.sv | 134 +++++++++++++
 tb/tb_mips_multicycle_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU ops.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic {
        EXT_SIGN,
        EXT_ZERO
    } ext_sel_t;

    // Add/sub wrap modulo 2^32; there is no overflow detection anywhere.
    function automatic logic [31:0] alu_eval(input alu_op_t op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] y;
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// Control FSM and instruction decode for the multi-cycle core; emits per-state datapath enables.
// Latency: one state per cycle; FETCH and MEM hold until mem_ready.
// Backpressure: mem_ready low in FETCH/MEM freezes the state and every enable.
// Ports: clk/rst_n; opcode/funct from IR; mem_ready, alu_zero, addr_misaligned from the datapath;
//        state plus load/write/select strobes back to the datapath.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       alu_zero,
    input  logic       addr_misaligned,
    output state_t     state,
    output logic       ir_load,
    output logic       decode_load,
    output logic       pc_jump,
    output logic       pc_branch,
    output logic       alu_out_load,
    output alu_op_t    alu_op,
    output ext_sel_t   ext_sel,
    output logic       alu_src_imm,
    output logic       mdr_load,
    output logic       reg_write,
    output logic       wb_from_mdr,
    output logic       dst_is_rd,
    output logic       mem_access,
    output logic       mem_we,
    output logic       retire
);

    state_t state_q, state_d;
    logic   is_r, is_j, is_beq, is_bne, is_lw, is_sw, legal;

    assign state = state_q;

    // Instruction decode; only meaningful once IR holds a fetched word.
    always_comb begin
        is_r        = (opcode == OP_RTYPE);
        is_j        = (opcode == OP_J);
        is_beq      = (opcode == OP_BEQ);
        is_bne      = (opcode == OP_BNE);
        is_lw       = (opcode == OP_LW);
        is_sw       = (opcode == OP_SW);
        legal       = 1'b0;
        alu_op      = ALU_ADD;
        ext_sel     = EXT_SIGN;
        alu_src_imm = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                alu_src_imm = 1'b0;
                legal       = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_SLT:          alu_op = ALU_SLT;
                    default:         legal  = 1'b0;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                alu_op      = ALU_SUB;
                alu_src_imm = 1'b0;
                legal       = 1'b1;
            end
            OP_ANDI: begin
                alu_op  = ALU_AND;
                ext_sel = EXT_ZERO;
                legal   = 1'b1;
            end
            OP_ORI: begin
                alu_op  = ALU_OR;
                ext_sel = EXT_ZERO;
                legal   = 1'b1;
            end
            OP_J, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!legal)    state_d = ST_HALT;
                else if (is_j) state_d = ST_FETCH;
                else           state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_beq || is_bne)    state_d = ST_FETCH;
                else if (is_lw || is_sw) state_d = addr_misaligned ? ST_HALT : ST_MEM;
                else                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready) state_d = is_sw ? ST_FETCH : ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        ir_load      = 1'b0;
        decode_load  = 1'b0;
        pc_jump      = 1'b0;
        pc_branch    = 1'b0;
        alu_out_load = 1'b0;
        mdr_load     = 1'b0;
        reg_write    = 1'b0;
        wb_from_mdr  = is_lw;
        dst_is_rd    = is_r;
        mem_access   = 1'b0;
        mem_we       = 1'b0;
        retire       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_access = 1'b1;
                ir_load    = mem_ready;
            end
            ST_DECODE: begin
                decode_load = 1'b1;
                // Illegal encodings must leave PC and retire untouched.
                if (legal && is_j) begin
                    pc_jump = 1'b1;
                    retire  = 1'b1;
                end
            end
            ST_EXEC: begin
                alu_out_load = 1'b1;
                if (is_beq || is_bne) begin
                    pc_branch = (is_beq && alu_zero) || (is_bne && !alu_zero);
                    retire    = 1'b1;
                end
            end
            ST_MEM: begin
                mem_access = 1'b1;
                mem_we     = is_sw;
                if (mem_ready) begin
                    retire   = is_sw;
                    mdr_load = !is_sw;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: datapath (regfile, ALU, PC/IR/A/B/MDR) around the mips_mc_ctrl FSM.
// Latency: j 2, beq/bne 3, ALU/sw 4, lw 5 cycles plus one per memory wait state.
// Backpressure: a request holds addr/we/wdata and the FSM until i_mem_ready; one request at a time.
// Ports: i_clk/i_rst_n; shared memory port o_mem_req/we/addr/wdata, i_mem_ready/rdata;
//        status o_pc (instruction in flight), o_retire (pulse), o_halt (sticky).
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [31:0]       i_mem_rdata,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_retire,
    output logic              o_halt
);

    state_t      state;
    logic        ir_load, decode_load, pc_jump, pc_branch, alu_out_load;
    logic        mdr_load, reg_write, wb_from_mdr, dst_is_rd, mem_access, mem_we, retire;
    alu_op_t     alu_op;
    ext_sel_t    ext_sel;
    logic        alu_src_imm;

    logic [ADDR_W-1:0] pc, pc_cur, target, jump_target;
    logic [31:0]       ir, a, b, mdr, alu_out;
    logic [31:0]       regs [32];
    logic              retire_q;

    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] rf_a, rf_b, imm_ext, alu_b, alu_y, wb_data;
    logic [31:0] br_off32, pc_ext, jt32;

    mips_mc_ctrl u_ctrl (
        .clk             (i_clk),
        .rst_n           (i_rst_n),
        .opcode          (ir[31:26]),
        .funct           (ir[5:0]),
        .mem_ready       (i_mem_ready),
        .alu_zero        (alu_y == 32'd0),
        .addr_misaligned (alu_y[1:0] != 2'b00),
        .state           (state),
        .ir_load         (ir_load),
        .decode_load     (decode_load),
        .pc_jump         (pc_jump),
        .pc_branch       (pc_branch),
        .alu_out_load    (alu_out_load),
        .alu_op          (alu_op),
        .ext_sel         (ext_sel),
        .alu_src_imm     (alu_src_imm),
        .mdr_load        (mdr_load),
        .reg_write       (reg_write),
        .wb_from_mdr     (wb_from_mdr),
        .dst_is_rd       (dst_is_rd),
        .mem_access      (mem_access),
        .mem_we          (mem_we),
        .retire          (retire)
    );

    assign rs  = ir[25:21];
    assign rt  = ir[20:16];
    assign rd  = ir[15:11];
    assign dst = dst_is_rd ? rd : rt;

    assign rf_a = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rf_b = (rt == 5'd0) ? 32'd0 : regs[rt];

    assign imm_ext = (ext_sel == EXT_ZERO) ? {16'b0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
    assign alu_b   = alu_src_imm ? imm_ext : b;
    assign alu_y   = alu_eval(alu_op, a, alu_b);
    assign wb_data = wb_from_mdr ? mdr : alu_out;

    // pc already holds PC+4 when DECODE runs, so both targets are formed from it.
    assign br_off32    = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign pc_ext      = 32'(pc);
    assign jt32        = (pc_ext & 32'hF000_0000) | {4'b0, ir[25:0], 2'b00};
    assign jump_target = jt32[ADDR_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc       <= RESET_VECTOR;
            pc_cur   <= RESET_VECTOR;
            target   <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            mdr      <= '0;
            alu_out  <= '0;
            retire_q <= 1'b0;
        end else begin
            retire_q <= retire;
            if (ir_load) begin
                ir     <= i_mem_rdata;
                pc     <= pc + ADDR_W'(4);
                pc_cur <= pc;
            end
            if (decode_load) begin
                a      <= rf_a;
                b      <= rf_b;
                target <= pc + br_off32[ADDR_W-1:0];
            end
            if (pc_jump)      pc      <= jump_target;
            if (pc_branch)    pc      <= target;
            if (alu_out_load) alu_out <= alu_y;
            if (mdr_load)     mdr     <= i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_write && dst != 5'd0) begin
            regs[dst] <= wb_data;
        end
    end

    // Gating with the reset pin drops an in-flight request the moment reset asserts
    // and keeps the port idle while reset is held.
    assign o_mem_req   = mem_access & i_rst_n;
    assign o_mem_we    = mem_we;
    assign o_mem_addr  = (state == ST_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign o_mem_wdata = b;
    assign o_pc        = pc_cur;
    assign o_retire    = retire_q;
    assign o_halt      = (state == ST_HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [31:0] mem [256];
    int          waits = 0;
    int          wcnt = 0;
    logic        held = 1'b0;
    logic        stable_err = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    int          wr_count = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    int          cyc, nret;

    int tests = 0;
    int fails = 0;
    int at, wr_base;

    mips_multicycle_core #(.ADDR_W(32), .RESET_VECTOR(32'h100)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ready (mem_ready),
        .i_mem_rdata (mem_rdata),
        .o_pc        (pc),
        .o_retire    (retire),
        .o_halt      (halt)
    );

    always #5 clk = ~clk;

    // Memory responder: `waits` wait states per access, writes on the completing edge.
    assign mem_ready = mem_req && (wcnt >= waits);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req) begin
            if (held && (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata))
                stable_err <= 1'b1;
            if (!mem_ready) begin
                wcnt    <= wcnt + 1;
                held    <= 1'b1;
                h_addr  <= mem_addr;
                h_we    <= mem_we;
                h_wdata <= mem_wdata;
            end else begin
                wcnt <= 0;
                held <= 1'b0;
            end
        end else begin
            wcnt <= 0;
            held <= 1'b0;
        end
        if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_count <= wr_count + 1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc  <= 0;
            nret <= 0;
        end else begin
            cyc  <= cyc + 1;
            nret <= nret + (retire ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_retire(input string tag, output int when);
        int n;
        n = 0;
        when = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < 200);
        if (retire) when = cyc;
        check({tag, "_retire_seen"}, {31'b0, retire}, 32'd1);
    endtask

    task automatic wait_halt(input string tag, output int when);
        int n;
        n = 0;
        when = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!halt && n < 200);
        if (halt) when = cyc;
        check({tag, "_halt_seen"}, {31'b0, halt}, 32'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] data);
        mem[addr[9:2]] = data;
    endtask

    initial begin
        clear_mem();
        put(32'h100, 32'h20010005);   // addi $1,$0,5
        put(32'h104, 32'h2002FFFD);   // addi $2,$0,-3
        put(32'h108, 32'h00221820);   // add  $3,$1,$2
        put(32'h10C, 32'h0041202A);   // slt  $4,$2,$1
        put(32'h110, 32'hAC030008);   // sw   $3,8($0)
        put(32'h114, 32'h8C050008);   // lw   $5,8($0)
        put(32'h118, 32'h08000000);   // j    0
        put(32'h000, 32'h10000002);   // beq  $0,$0,+2
        put(32'h004, 32'hFC000000);   // illegal (must be skipped)
        put(32'h008, 32'hFC000000);   // illegal (must be skipped)
        put(32'h00C, 32'h14000005);   // bne  $0,$0,+5 (not taken)
        put(32'h010, 32'h08000040);   // j    0x40 -> 0x100

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req",    {31'b0, mem_req},   32'd0);
        check("rst_we",     {31'b0, mem_we},    32'd0);
        check("rst_addr",   mem_addr,           32'h100);
        check("rst_wdata",  mem_wdata,          32'h0);
        check("rst_retire", {31'b0, retire},    32'd0);
        check("rst_halt",   {31'b0, halt},      32'd0);
        check("rst_pc",     pc,                 32'h100);

        rst_n = 1'b1;
        #1;
        check("first_req",  {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr,         32'h100);
        check("first_we",   {31'b0, mem_we},  32'd0);

        for (int k = 1; k <= 4; k++) begin
            wait_retire("alu", at);
            check("alu_retire_cycle", at, 32'(4 * k));
        end
        check("reg1", dut.regs[1], 32'd5);
        check("reg2", dut.regs[2], 32'hFFFFFFFD);
        check("reg3", dut.regs[3], 32'd2);
        check("reg4", dut.regs[4], 32'd1);

        waits   = 3;
        wr_base = wr_count;
        wait_retire("sw", at);
        check("sw_retire_cycle", at, 32'd26);
        check("sw_write_count", wr_count - wr_base, 32'd1);
        check("sw_write_addr",  wr_addr, 32'h8);
        check("sw_write_data",  wr_data, 32'd2);
        wait_retire("lw", at);
        check("lw_retire_cycle", at, 32'd37);
        check("reg5", dut.regs[5], 32'd2);
        check("req_stable", {31'b0, stable_err}, 32'd0);

        waits = 0;
        wait_retire("j0", at);
        check("j0_retire_cycle", at, 32'd39);
        check("j0_next_fetch", mem_addr, 32'h0);
        check("j0_next_req", {31'b0, mem_req}, 32'd1);
        wait_retire("beq", at);
        check("beq_retire_cycle", at, 32'd42);
        check("beq_next_fetch", mem_addr, 32'hC);
        check("beq_pc", pc, 32'h0);
        wait_retire("bne", at);
        check("bne_retire_cycle", at, 32'd45);
        check("bne_next_fetch", mem_addr, 32'h10);
        wait_retire("j40", at);
        check("j40_retire_cycle", at, 32'd47);
        check("j40_next_fetch", mem_addr, 32'h100);
        check("j40_pc", pc, 32'h10);

        // Reset while a fetch is outstanding.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req",  {31'b0, mem_req}, 32'd0);
        check("midrst_pc",   pc, 32'h100);
        check("midrst_reg3", dut.regs[3], 32'd0);

        // Illegal opcode 0x3F after one good instruction.
        clear_mem();
        put(32'h100, 32'h20010007);   // addi $1,$0,7
        put(32'h104, 32'hFC000000);   // opcode 0x3F
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        wr_base = wr_count;
        wait_retire("ill_addi", at);
        check("ill_addi_cycle", at, 32'd4);
        wait_halt("ill", at);
        check("ill_halt_cycle", at, 32'd6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ill_req_low", {31'b0, mem_req}, 32'd0);
        end
        check("ill_halt_sticky", {31'b0, halt}, 32'd1);
        check("ill_reg1", dut.regs[1], 32'd7);
        check("ill_retires", nret, 32'd1);
        check("ill_no_write", wr_count - wr_base, 32'd0);

        rst_n = 1'b0;
        #1;
        check("halt_cleared", {31'b0, halt}, 32'd0);

        // Misaligned lw at byte address 6.
        clear_mem();
        put(32'h100, 32'h20060009);   // addi $6,$0,9
        put(32'h104, 32'h8C060006);   // lw   $6,6($0)
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        wr_base = wr_count;
        wait_retire("mis_addi", at);
        check("mis_addi_cycle", at, 32'd4);
        wait_halt("mis", at);
        check("mis_halt_cycle", at, 32'd7);
        repeat (3) @(negedge clk);
        check("mis_req_low", {31'b0, mem_req}, 32'd0);
        check("mis_reg6", dut.regs[6], 32'd9);
        check("mis_retires", nret, 32'd1);
        check("mis_no_write", wr_count - wr_base, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
